bti_rom_slave: RTL and testbench

//  Read-only BTI slave wrapping a word-wide ROM array; serves as the core's instruction TCM (ITCM).

---
 rtl/bti_rom_slave.sv | 81 ++++++++
 tb/tb_bti_rom_slave.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bti_rom_slave.sv
// bti_rom_slave: read-only BTI slave over a word-wide ROM (ITCM), one response per cycle, 1-cycle latency.
// Optional macro BTI_ROM_WR_ERR_EN: accepted writes return rsp_err=1 with zero data instead of a silent drop.
module bti_rom_array #(
    parameter int DW = 32,
    parameter int AW = 15
) (
    input  logic [AW-1:0] i_idx,
    output logic [DW-1:0] o_rdata
);
    // Contents are preloaded hierarchically; the array has no write port and no reset.
    logic [DW-1:0] mem [0:2**AW-1];
    assign o_rdata = mem[i_idx];
endmodule

module bti_rom_slave #(
    parameter int BTI_AW = 32,
    parameter int BTI_DW = 32,
    parameter int ROM_AW = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_vld,
    output logic                req_rdy,
    input  logic [BTI_AW-1:0]   req_addr,
    input  logic                req_wr,
    input  logic [BTI_DW-1:0]   req_wdata,
    input  logic [BTI_DW/8-1:0] req_strb,
    output logic                rsp_vld,
    input  logic                rsp_rdy,
    output logic [BTI_DW-1:0]   rsp_rdata,
    output logic                rsp_err
);
    localparam int W = $clog2(BTI_DW / 8);

    logic              r_vld;
    logic [BTI_DW-1:0] r_rdata;
    logic              r_err;
    logic              w_acc;
    logic [ROM_AW-1:0] w_idx;
    logic [BTI_DW-1:0] w_mem;
    logic [BTI_DW-1:0] w_data;
    logic              w_err;
    logic              w_unused;

    assign w_idx   = req_addr[ROM_AW+W-1:W];
    assign req_rdy = !r_vld || rsp_rdy;
    assign w_acc   = req_vld && req_rdy;
    // Write payload, strobes and out-of-range address bits carry no meaning for a ROM.
    assign w_unused = &{1'b0, req_wdata, req_strb, req_addr, req_wr};

    bti_rom_array #(.DW(BTI_DW), .AW(ROM_AW)) u_rom (
        .i_idx   (w_idx),
        .o_rdata (w_mem)
    );

`ifdef BTI_ROM_WR_ERR_EN
    assign w_err  = req_wr;
    assign w_data = req_wr ? '0 : w_mem;
`else
    assign w_err  = 1'b0;
    assign w_data = w_mem;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_acc) begin
            r_vld   <= 1'b1;
            r_rdata <= w_data;
            r_err   <= w_err;
        end else if (rsp_rdy) begin
            r_vld   <= 1'b0;
        end
    end

    assign rsp_vld   = r_vld;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
endmodule

// File: tb/tb_bti_rom_slave.sv
// tb_bti_rom_slave: directed stimulus for bti_rom_slave with a queue scoreboard of expected responses.
module tb_bti_rom_slave;
    localparam int BTI_AW = 32;
    localparam int BTI_DW = 32;
    localparam int ROM_AW = 15;
`ifdef BTI_ROM_WR_ERR_EN
    localparam bit WR_ERR = 1'b1;
`else
    localparam bit WR_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_vld = 1'b0;
    logic        req_wr = 1'b0;
    logic        rsp_rdy = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_strb = 4'hF;
    logic        req_rdy;
    logic        rsp_vld;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    logic [32:0] sb [$];
    logic [31:0] model [int];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bti_rom_slave #(.BTI_AW(BTI_AW), .BTI_DW(BTI_DW), .ROM_AW(ROM_AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_addr  (req_addr),
        .req_wr    (req_wr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [32:0] expect_rsp(input logic [31:0] a, input logic w);
        return (w && WR_ERR) ? {32'h0, 1'b1} : {model[int'(a[ROM_AW+1:2])], 1'b0};
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, input logic w, input logic r);
        req_vld   = v;
        req_addr  = a;
        req_wr    = w;
        req_wdata = w ? 32'hDEADBEEF : 32'h0;
        rsp_rdy   = r;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Consume the response being handed over this cycle, then record any newly accepted request.
    always @(negedge clk) begin : monitor
        logic [32:0] e;
        if (!rst) begin
            if (rsp_vld && rsp_rdy) begin
                if (sb.size() == 0) check("sb_spurious", 64'(rsp_vld), 64'd0);
                else begin
                    e = sb.pop_front();
                    check("sb_rdata", 64'(rsp_rdata), 64'(e[32:1]));
                    check("sb_err", 64'(rsp_err), 64'(e[0]));
                end
            end
            if (req_vld && req_rdy) sb.push_back(expect_rsp(req_addr, req_wr));
        end
    end

    initial begin
        logic [31:0] t2a [3];
        t2a = '{32'h0, 32'h4, 32'hC};
        model[0] = 32'h11111111;
        model[1] = 32'h22222222;
        model[2] = 32'h33333333;
        model[3] = 32'h44444444;
        model[2**ROM_AW-1] = 32'h55555555;
        foreach (model[k]) dut.u_rom.mem[15'(k)] = model[k];

        #1;
        check("rst_vld", 64'(rsp_vld), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        check("rst_rdy", 64'(req_rdy), 64'd1);
        cyc();
        rst = 1'b0;

        drive(1'b1, 32'h8, 1'b0, 1'b1);
        cyc();
        check("t1_lat_vld", 64'(rsp_vld), 64'd1);
        check("t1_rdata", 64'(rsp_rdata), 64'h33333333);
        check("t1_err", 64'(rsp_err), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        cyc();
        check("t1_drain", 64'(rsp_vld), 64'd0);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, t2a[i], 1'b0, 1'b1);
            check("t2_rdy", 64'(req_rdy), 64'd1);
            cyc();
            check("t2_vld", 64'(rsp_vld), 64'd1);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        cyc();
        check("t2_drain", 64'(rsp_vld), 64'd0);

        drive(1'b1, 32'h4, 1'b0, 1'b0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0, 1'b0, 1'b0);
            check("t3_rdy_low", 64'(req_rdy), 64'd0);
            check("t3_hold_rdata", 64'(rsp_rdata), 64'h22222222);
            check("t3_hold_vld", 64'(rsp_vld), 64'd1);
            cyc();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        check("t3_rdy_back", 64'(req_rdy), 64'd1);
        cyc();
        check("t3_drain", 64'(rsp_vld), 64'd0);

        drive(1'b1, 32'h6, 1'b0, 1'b1);
        cyc();
        check("t4_misalign", 64'(rsp_rdata), 64'h22222222);
        drive(1'b1, 32'h4 + (32'd1 << (ROM_AW + 2)), 1'b0, 1'b1);
        cyc();
        check("t4_alias", 64'(rsp_rdata), 64'h22222222);
        drive(1'b1, 32'((2**ROM_AW - 1) * 4), 1'b0, 1'b1);
        cyc();
        check("t4_last_word", 64'(rsp_rdata), 64'h55555555);
        drive(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
        cyc();
        check("t4_top_alias", 64'(rsp_rdata), 64'h55555555);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        cyc();

        drive(1'b1, 32'h0, 1'b1, 1'b1);
        cyc();
        check("t5_wr_vld", 64'(rsp_vld), 64'd1);
        check("t5_wr_err", 64'(rsp_err), 64'(WR_ERR));
        drive(1'b1, 32'h0, 1'b0, 1'b1);
        cyc();
        check("t5_rd_after_wr", 64'(rsp_rdata), 64'h11111111);
        check("t5_rd_err", 64'(rsp_err), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        cyc();

        drive(1'b1, 32'hC, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("t6_pending", 64'(rsp_vld), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_async_vld", 64'(rsp_vld), 64'd0);
        check("t6_async_rdata", 64'(rsp_rdata), 64'd0);
        check("t6_async_err", 64'(rsp_err), 64'd0);
        check("t6_rst_rdy", 64'(req_rdy), 64'd1);
        sb.delete();
        cyc();
        rst = 1'b0;
        drive(1'b1, 32'h0, 1'b0, 1'b1);
        check("t6_rel_rdy", 64'(req_rdy), 64'd1);
        cyc();
        check("t6_rel_vld", 64'(rsp_vld), 64'd1);
        check("t6_rel_rdata", 64'(rsp_rdata), 64'h11111111);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        cyc();
        cyc();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
